// File: rtl/mp64_sram_arb_if.sv
// Bus bundle between the port-B arbiter, its two requesters, the snooped
// port A and the SRAM port B.
interface mp64_sram_arb_if #(
  parameter int unsigned ADDR_W_A = 14,
  parameter int unsigned ADDR_W_B = 17,
  parameter int unsigned DATA_W_B = 64
);
  // requester 0 (CPU)
  logic                r0_req;
  logic                r0_we;
  logic [ADDR_W_B-1:0] r0_addr;
  logic [DATA_W_B-1:0] r0_wdata;
  logic                r0_gnt;
  logic                r0_rvalid;
  logic [DATA_W_B-1:0] r0_rdata;
  // requester 1 (DMA)
  logic                r1_req;
  logic                r1_we;
  logic [ADDR_W_B-1:0] r1_addr;
  logic [DATA_W_B-1:0] r1_wdata;
  logic                r1_gnt;
  logic                r1_rvalid;
  logic [DATA_W_B-1:0] r1_rdata;
  // snooped port A
  logic                a_ce;
  logic                a_we;
  logic [ADDR_W_A-1:0] a_addr;
  // SRAM port B
  logic                b_ce;
  logic                b_we;
  logic [ADDR_W_B-1:0] b_addr;
  logic [DATA_W_B-1:0] b_wdata;
  logic [DATA_W_B-1:0] b_rdata;

  // arbiter view
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    input  a_ce, a_we, a_addr,
    output b_ce, b_we, b_addr, b_wdata,
    input  b_rdata
  );

  // environment view: requesters, port-A snoop source and SRAM
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    output a_ce, a_we, a_addr,
    input  b_ce, b_we, b_addr, b_wdata,
    output b_rdata
  );
endinterface

// File: rtl/mp64_sram_arb.sv
// Round-robin arbiter for the 64-bit port B of the tile/CPU dual-port SRAM.
// Blocks port-B accesses that collide with a port-A access to the same wide
// row, and routes read data back to the issuing requester after RD_LAT cycles.
module mp64_sram_arb #(
  parameter int unsigned ADDR_W_A = 14,
  parameter int unsigned ADDR_W_B = 17,
  parameter int unsigned DATA_W_B = 64,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  mp64_sram_arb_if.slave bus,
  output logic [15:0] coll_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ADDR_W_A-1:0] row0;
  logic [ADDR_W_A-1:0] row1;
  logic                haz0;
  logic                haz1;
  logic                elig0;
  logic                elig1;
  logic                gnt0;
  logic                gnt1;
  logic                prio;
  logic                rd_load;
  logic [RD_LAT-1:0]   pipe_vld;
  logic [RD_LAT-1:0]   pipe_id;
  logic                rsp_vld;

  // Wide-row index of each requester's sub-word address
  assign row0 = bus.r0_addr[ADDR_W_B-1 -: ADDR_W_A];
  assign row1 = bus.r1_addr[ADDR_W_B-1 -: ADDR_W_A];

  // A port-A write, or any port-B write, to the same row is a hazard
  assign haz0  = bus.a_ce & (bus.a_we | bus.r0_we) & (bus.a_addr == row0);
  assign haz1  = bus.a_ce & (bus.a_we | bus.r1_we) & (bus.a_addr == row1);
  assign elig0 = bus.r0_req & ~haz0;
  assign elig1 = bus.r1_req & ~haz1;

  // Grant selection: lone eligible requester wins, prio breaks ties
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (elig0 && (!elig1 || !prio)) begin
        gnt0 = 1'b1;
      end else if (elig1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign bus.r0_gnt  = gnt0;
  assign bus.r1_gnt  = gnt1;

  // Port-B drive follows the winner; address/data are don't-care when idle
  assign bus.b_ce    = gnt0 | gnt1;
  assign bus.b_we    = (gnt0 & bus.r0_we) | (gnt1 & bus.r1_we);
  assign bus.b_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
  assign bus.b_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;

  assign rd_load = bus.b_ce & ~bus.b_we;

  // Round-robin pointer: the loser of the last grant is preferred next
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end

  // Read-return pipeline tracking {valid, id} for RD_LAT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= rd_load;
      pipe_id[0]  <= gnt1;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // Reset also suppresses a response already at the pipeline head
  assign rsp_vld       = pipe_vld[RD_LAT-1] & ~rst;
  assign bus.r0_rvalid = rsp_vld & ~pipe_id[RD_LAT-1];
  assign bus.r1_rvalid = rsp_vld &  pipe_id[RD_LAT-1];
  assign bus.r0_rdata  = bus.b_rdata;
  assign bus.r1_rdata  = bus.b_rdata;

  // Saturating count of cycles where a requester was held off by a hazard
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt <= '0;
    end else if (((bus.r0_req & haz0) | (bus.r1_req & haz1)) && (coll_cnt != CNT_MAX)) begin
      coll_cnt <= coll_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/mp64_sram_arb.md
# mp64_sram_arb

Two-requester arbiter and hazard guard for the narrow (64-bit) port B of the shared tile/CPU dual-port SRAM. It shares port B between the CPU (requester 0) and the DMA engine (requester 1) using round-robin priority. It snoops port A, driven by the tile engine, and blocks any port-B access that would collide with a port-A access to the same wide row in the same cycle. It also returns read data to the requester that issued each read, aligned to the SRAM's read latency.

## Interface
Parameters:
- ADDR_W_A, 14, port-A (row) address width
- ADDR_W_B, 17, port-B (sub-word) address width; row = b_addr[ADDR_W_B-1 -: ADDR_W_A]
- DATA_W_B, 64, port-B data width
- RD_LAT, 1, SRAM port-B read latency in cycles (1 = no output register, 2 = OUT_REG_B); legal values 1..2

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- r0_req / r1_req  in  1  request valid; held with its fields until granted
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  ADDR_W_B  sub-word address
- r0_wdata / r1_wdata  in  DATA_W_B  write data
- r0_gnt / r1_gnt  out  1  request accepted this cycle (combinational)
- r0_rvalid / r1_rvalid  out  1  read data valid for that requester (registered)
- r0_rdata / r1_rdata  out  DATA_W_B  read data; both are driven from b_rdata
- a_ce, a_we  in  1  snooped port-A enable / write
- a_addr  in  ADDR_W_A  snooped port-A row address
- b_ce, b_we  out  1  SRAM port-B enable / write (combinational)
- b_addr  out  ADDR_W_B  SRAM port-B address
- b_wdata  out  DATA_W_B  SRAM port-B write data
- b_rdata  in  DATA_W_B  SRAM port-B read data
- coll_cnt  out  16  saturating count of hazard-blocked cycles

## Operation
Hazard test:
- hazN = a_ce & (a_we | rN_we) & (a_addr == row(rN_addr)).
- A read against a port-A read of the same row is not a hazard.
- eligN = rN_req & ~hazN.

Arbitration:
- One grant at most per cycle.
- If exactly one requester is eligible, it is granted.
- If both are eligible, the requester selected by prio wins.
- prio is 1 bit: 0 = r0 preferred.
- On any grant to requester X, prio <= ~X at the clock edge.
- prio is unchanged on cycles with no grant.

Port-B drive:
- When a grant is issued: b_ce = 1, and b_we, b_addr, b_wdata are the winner's fields.
- Otherwise b_ce = 0 and b_we = 0; b_addr and b_wdata are don't-care.

Read return:
- A shift pipeline of RD_LAT stages holds {valid, id}.
- A stage is loaded with valid=1 only on a granted read.
- When the last stage is valid, rvalid is asserted for the recorded id and rdata = b_rdata.
- Writes produce no response.

Collision counter:
- coll_cnt increments by 1 in any cycle where (r0_req & haz0) | (r1_req & haz1).
- It saturates at 0xFFFF; it does not wrap.

Reset (rst=1):
- Outputs: all gnt = 0, b_ce = 0, b_we = 0, all rvalid = 0.
- State: prio <= 0, pipeline cleared, coll_cnt <= 0.
- Reads in flight when reset is asserted are dropped; no rvalid is issued for them, even after reset releases.

## Timing
- Request to grant: 0 cycles. gnt is asserted in the same cycle as rN_req when the requester is eligible and wins.
- Handshake: the transfer occurs on the edge where req & gnt. The requester may change its fields on the next cycle.
- Read latency: a read granted in cycle N gives rvalid in cycle N+RD_LAT with the matching b_rdata. Back-to-back reads produce back-to-back rvalid, in grant order.
- Write completes at the grant edge. A read of the same address granted at N+1 returns the new data.
- Hazard stall: a blocked requester is retried every cycle with no penalty cycles. If both are blocked, nothing is issued and coll_cnt increments once.
- Simultaneous events:
  - Winner blocked and loser eligible: the loser is granted that cycle.
  - r0 and r1 requesting the same row: no conflict; they are serialized by arbitration.

## Test plan
- Reset behaviour: rst=1 with r0_req=1 → r0_gnt=0, b_ce=0, coll_cnt=0. Release rst → r0 is granted in the first cycle; prio becomes 1.
- Round-robin: r0_req and r1_req held high with reads for 4 cycles, a_ce=0 → grants r0, r1, r0, r1. The rvalid ids follow the same order RD_LAT cycles later.
- Read latency, RD_LAT=2: r1 reads addr 0x00010; the SRAM model holds 0xDEAD_BEEF_0000_0001 → r1_rvalid at grant+2 with that data; r0_rvalid stays 0.
- Hazard: a_ce=1, a_we=1, a_addr=0x0002; r0 writes addr 0x00011 (row 2), r1 reads addr 0x00040 → r1 granted, r0 blocked, coll_cnt=1. The next cycle with a_ce=0 → r0 granted.
- Read/read no hazard: a_ce=1, a_we=0, a_addr=5; r0 reads addr 0x0002A (row 5) → r0 granted, coll_cnt unchanged.
- Saturation and reset mid-read: force 70000 blocked cycles → coll_cnt=0xFFFF. Then grant a read and assert rst the next cycle → no rvalid is ever issued for that read.
